// File: rtl/tftlcd_window_ctrl.sv
// TFT-LCD timing generator with linear frame-buffer addressing and a movable
// rectangular window; pixels outside the window are blanked to black.
module tftlcd_window_ctrl #(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 2,
    parameter int H_SYNC   = 41,
    parameter int H_BP     = 2,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 10,
    parameter int V_BP     = 2,
    parameter int CW       = 8,
    parameter int WIN_W    = 64,
    parameter int WIN_H    = 64,
    parameter int STEP_S   = 5,
    parameter int STEP_L   = 10,
    parameter int SYNC_POL = 0,
    parameter int ADDR_W   = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [3:0]        btn,
    input  logic              step_sel,
    input  logic [CW-1:0]     pix_r,
    input  logic [CW-1:0]     pix_g,
    input  logic [CW-1:0]     pix_b,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [CW-1:0]     r,
    output logic [CW-1:0]     g,
    output logic [CW-1:0]     b,
    output logic              frame_start,
    output logic [9:0]        win_x,
    output logic [9:0]        win_y
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] WIN_W_C  = 11'(WIN_W);
    localparam logic [10:0] WIN_H_C  = 11'(WIN_H);
    localparam logic [10:0] X_MAX    = 11'(H_ACTIVE - WIN_W);
    localparam logic [10:0] Y_MAX    = 11'(V_ACTIVE - WIN_H);
    localparam logic [10:0] STEP_S_C = 11'(STEP_S);
    localparam logic [10:0] STEP_L_C = 11'(STEP_L);
    localparam logic [9:0]  X_RST    = 10'((H_ACTIVE - WIN_W) / 2);
    localparam logic [9:0]  Y_RST    = 10'((V_ACTIVE - WIN_H) / 2);
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic SYNC_ON = 1'(SYNC_POL);

    logic [10:0] h, v;
    logic [3:0]  btn_q, pend, rise;
    logic        sof, raw_act, raw_hs, raw_vs, hit;
    logic        s1_act, s1_hs, s1_vs, s1_hit;
    logic [10:0] step, x_inc, x_dec, y_inc, y_dec;
    logic [9:0]  x_nx, y_nx;

    assign sof     = (h == '0) && (v == '0);
    assign rise    = btn & ~btn_q;
    assign raw_act = (h < H_ACT) && (v < V_ACT);
    assign raw_hs  = (h >= HS_BEG) && (h < HS_END);
    assign raw_vs  = (v >= VS_BEG) && (v < VS_END);

    // Moves land at frame start; the 11th bit catches overflow/borrow so the
    // window saturates instead of wrapping.
    always_comb begin
        step  = step_sel ? STEP_L_C : STEP_S_C;
        x_inc = {1'b0, win_x} + step;
        x_dec = {1'b0, win_x} - step;
        y_inc = {1'b0, win_y} + step;
        y_dec = {1'b0, win_y} - step;
        x_nx  = win_x;
        y_nx  = win_y;
        if (sof) begin
            if (pend[3] && !pend[2])
                x_nx = (x_inc > X_MAX) ? X_MAX[9:0] : x_inc[9:0];
            else if (pend[2] && !pend[3])
                x_nx = x_dec[10] ? 10'd0 : x_dec[9:0];
            if (pend[1] && !pend[0])
                y_nx = (y_inc > Y_MAX) ? Y_MAX[9:0] : y_inc[9:0];
            else if (pend[0] && !pend[1])
                y_nx = y_dec[10] ? 10'd0 : y_dec[9:0];
        end
    end

    // Hit uses the post-update window so the whole frame sees one position.
    assign hit = ({1'b0, x_nx} <= h) && (h < ({1'b0, x_nx} + WIN_W_C)) &&
                 ({1'b0, y_nx} <= v) && (v < ({1'b0, y_nx} + WIN_H_C));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (en) begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + 11'd1;
            end else begin
                h <= h + 11'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q       <= '0;
            pend        <= '0;
            win_x       <= X_RST;
            win_y       <= Y_RST;
            frame_start <= 1'b0;
            fb_addr     <= '0;
            s1_act      <= 1'b0;
            s1_hs       <= 1'b0;
            s1_vs       <= 1'b0;
            s1_hit      <= 1'b0;
        end else if (en) begin
            btn_q       <= btn;
            pend        <= sof ? rise : (pend | rise);
            win_x       <= x_nx;
            win_y       <= y_nx;
            frame_start <= sof;
            if (sof)
                fb_addr <= '0;
            else if (s1_act && (fb_addr != ADDR_MAX))
                fb_addr <= fb_addr + ADDR_W'(1);
            s1_act      <= raw_act;
            s1_hs       <= raw_hs;
            s1_vs       <= raw_vs;
            s1_hit      <= hit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync <= ~SYNC_ON;
            vsync <= ~SYNC_ON;
            de    <= 1'b0;
            r     <= '0;
            g     <= '0;
            b     <= '0;
        end else if (en) begin
            hsync <= s1_hs ? SYNC_ON : ~SYNC_ON;
            vsync <= s1_vs ? SYNC_ON : ~SYNC_ON;
            de    <= s1_act;
            r     <= (s1_act && s1_hit) ? pix_r : '0;
            g     <= (s1_act && s1_hit) ? pix_g : '0;
            b     <= (s1_act && s1_hit) ? pix_b : '0;
        end
    end

endmodule
